// File: rtl/wb_stage.sv
// Write-back stage: commits register-file, CP0 and TLB side effects, raises exceptions/eret
// and drives the pipeline-wide flush, the forward/block bus to decode and the debug trace.
module wb_stage #(
    parameter int          BUS_WD       = 134,
    parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
    parameter logic [31:0] REFILL_ENTRY = 32'hbfc00200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    input  logic [BUS_WD-1:0] ms_to_ws_bus,
    output logic              ws_allowin,
    output logic [3:0]        rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [41:0]       ws_fwd_blk_bus,
    output logic              cp0_we,
    output logic [7:0]        cp0_addr,
    output logic [31:0]       cp0_wdata,
    input  logic [31:0]       cp0_rdata,
    input  logic [31:0]       cp0_epc,
    output logic              ws_ex,
    output logic [4:0]        ws_excode,
    output logic [31:0]       ws_badvaddr,
    output logic              ws_bd,
    output logic [31:0]       ws_pc,
    output logic              ws_eret,
    output logic              tlbp_we,
    output logic              tlbp_found,
    output logic [3:0]        tlbp_index,
    output logic              tlbr_we,
    output logic              tlbwi_we,
    output logic              do_flush,
    output logic [31:0]       flush_pc,
    output logic              after_ex,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    typedef struct packed {
        logic        tlb_refill;
        logic [3:0]  s1_index;
        logic        s1_found;
        logic        after_tlb;
        logic        tlbp;
        logic        tlbr;
        logic        tlbwi;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  cp0_addr;
        logic        ex;
        logic        bd;
        logic        eret;
        logic        syscall;
        logic        mfc0;
        logic        mtc0;
        logic [3:0]  gr_strb;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_bus_t;

    ms_bus_t     bus_r;
    logic        ws_valid;
    logic        commit;
    logic [31:0] final_data;
    logic        unused_bits;

    assign ws_allowin = 1'b1;

    // A flush squashes whatever memory offers in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
            after_ex <= 1'b0;
            bus_r    <= '0;
        end else begin
            ws_valid <= ms_to_ws_valid & ~do_flush;
            if (ms_to_ws_valid && ws_allowin)
                bus_r <= ms_to_ws_bus;
            if (do_flush)
                after_ex <= 1'b1;
            else if (ms_to_ws_valid && ws_allowin)
                after_ex <= 1'b0;
        end
    end

    assign commit     = ws_valid & ~bus_r.ex;
    assign final_data = bus_r.mfc0 ? cp0_rdata : bus_r.result;

    assign rf_we    = {4{commit}} & bus_r.gr_strb;
    assign rf_waddr = bus_r.dest;
    assign rf_wdata = final_data;

    // mfc0 data arrives too late to forward, so decode is told to stall instead.
    assign ws_fwd_blk_bus = {rf_we, bus_r.dest, final_data, ws_valid & bus_r.mfc0};

    assign cp0_we     = commit & bus_r.mtc0;
    assign cp0_addr   = bus_r.cp0_addr;
    assign cp0_wdata  = bus_r.result;
    assign ws_eret    = commit & bus_r.eret;
    assign tlbp_we    = commit & bus_r.tlbp;
    assign tlbp_found = bus_r.s1_found;
    assign tlbp_index = bus_r.s1_index;
    assign tlbr_we    = commit & bus_r.tlbr;
    assign tlbwi_we   = commit & bus_r.tlbwi;

    assign ws_ex       = ws_valid & bus_r.ex;
    assign ws_excode   = bus_r.excode;
    assign ws_badvaddr = bus_r.badvaddr;
    assign ws_bd       = bus_r.bd;
    assign ws_pc       = bus_r.pc;

    assign do_flush = ws_valid & (bus_r.ex | bus_r.eret | bus_r.after_tlb);

    always_comb begin
        flush_pc = 32'h0;
        if (bus_r.ex)
            flush_pc = bus_r.tlb_refill ? REFILL_ENTRY : EX_ENTRY;
        else if (bus_r.eret)
            flush_pc = cp0_epc;
        else if (bus_r.after_tlb)
            flush_pc = bus_r.pc + 32'd4;
    end

    assign debug_wb_pc       = bus_r.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = bus_r.dest;
    assign debug_wb_rf_wdata = final_data;

    // syscall is already folded into ex/excode upstream.
    assign unused_bits = bus_r.syscall;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, hand sequences for flush/squash/reset,
// and random traffic compared every cycle against an instruction-level model.
module tb_wb_stage;

    typedef struct packed {
        logic        tlb_refill;
        logic [3:0]  s1_index;
        logic        s1_found;
        logic        after_tlb;
        logic        tlbp;
        logic        tlbr;
        logic        tlbwi;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [7:0]  cp0_addr;
        logic        ex;
        logic        bd;
        logic        eret;
        logic        syscall;
        logic        mfc0;
        logic        mtc0;
        logic [3:0]  gr_strb;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } bus_t;

    typedef struct {
        bus_t        b;
        logic [31:0] rdata;
        logic [31:0] epc;
    } ins_t;

    typedef struct {
        string       name;
        ins_t        in;
        logic [3:0]  e_we;
        logic [31:0] e_wdata;
        logic        e_blk;
        logic        e_ex;
        logic        e_eret;
        logic        e_tlbwi;
        logic        e_flush;
        logic [31:0] e_fpc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic ms_to_ws_valid;
    logic [133:0] ms_to_ws_bus;
    logic ws_allowin;
    logic [3:0] rf_we;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;
    logic [41:0] ws_fwd_blk_bus;
    logic cp0_we;
    logic [7:0] cp0_addr;
    logic [31:0] cp0_wdata, cp0_rdata, cp0_epc;
    logic ws_ex;
    logic [4:0] ws_excode;
    logic [31:0] ws_badvaddr;
    logic ws_bd;
    logic [31:0] ws_pc;
    logic ws_eret, tlbp_we, tlbp_found;
    logic [3:0] tlbp_index;
    logic tlbr_we, tlbwi_we, do_flush;
    logic [31:0] flush_pc;
    logic after_ex;
    logic [31:0] debug_wb_pc;
    logic [3:0] debug_wb_rf_wen;
    logic [4:0] debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_fwd_blk_bus(ws_fwd_blk_bus), .cp0_we(cp0_we), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .cp0_epc(cp0_epc), .ws_ex(ws_ex),
        .ws_excode(ws_excode), .ws_badvaddr(ws_badvaddr), .ws_bd(ws_bd), .ws_pc(ws_pc),
        .ws_eret(ws_eret), .tlbp_we(tlbp_we), .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
        .tlbr_we(tlbr_we), .tlbwi_we(tlbwi_we), .do_flush(do_flush), .flush_pc(flush_pc),
        .after_ex(after_ex), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: the instruction currently in write-back, whether it is live, and the post-flush flag.
    ins_t m_cur;
    logic m_v;
    logic m_aex;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t i;
        i.b = '0;
        i.rdata = 32'h0;
        i.epc = 32'h0;
        return i;
    endfunction

    function automatic logic m_flush();
        return m_v && (m_cur.b.ex || m_cur.b.eret || m_cur.b.after_tlb);
    endfunction

    // Expected outputs from the architectural meaning of the instruction in the stage.
    task automatic check_all();
        logic        live_ok;
        logic [3:0]  we;
        logic [31:0] data, fpc;
        live_ok = m_v && !m_cur.b.ex;
        we   = live_ok ? m_cur.b.gr_strb : 4'h0;
        data = m_cur.b.mfc0 ? m_cur.rdata : m_cur.b.result;
        if (m_cur.b.ex)             fpc = m_cur.b.tlb_refill ? 32'hbfc00200 : 32'hbfc00380;
        else if (m_cur.b.eret)      fpc = m_cur.epc;
        else                        fpc = m_cur.b.pc + 32'd4;
        chk("allowin", 64'(ws_allowin), 64'd1);
        chk("rf_we", 64'(rf_we), 64'(we));
        chk("dbg_wen", 64'(debug_wb_rf_wen), 64'(we));
        chk("fwd_bus", 64'(ws_fwd_blk_bus), 64'({we, m_cur.b.dest, data, m_v && m_cur.b.mfc0}));
        chk("cp0_we", 64'(cp0_we), 64'(live_ok && m_cur.b.mtc0));
        chk("eret", 64'(ws_eret), 64'(live_ok && m_cur.b.eret));
        chk("tlbp_we", 64'(tlbp_we), 64'(live_ok && m_cur.b.tlbp));
        chk("tlbr_we", 64'(tlbr_we), 64'(live_ok && m_cur.b.tlbr));
        chk("tlbwi_we", 64'(tlbwi_we), 64'(live_ok && m_cur.b.tlbwi));
        chk("ws_ex", 64'(ws_ex), 64'(m_v && m_cur.b.ex));
        chk("do_flush", 64'(do_flush), 64'(m_flush()));
        chk("after_ex", 64'(after_ex), 64'(m_aex));
        if (we != 0) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(m_cur.b.dest));
            chk("rf_wdata", 64'(rf_wdata), 64'(data));
            chk("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(m_cur.b.dest));
            chk("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(data));
        end
        if (m_v) chk("dbg_pc", 64'(debug_wb_pc), 64'(m_cur.b.pc));
        if (m_flush()) chk("flush_pc", 64'(flush_pc), 64'(fpc));
        if (m_v && m_cur.b.ex) begin
            chk("excode", 64'(ws_excode), 64'(m_cur.b.excode));
            chk("badvaddr", 64'(ws_badvaddr), 64'(m_cur.b.badvaddr));
            chk("bd", 64'(ws_bd), 64'(m_cur.b.bd));
            chk("ws_pc", 64'(ws_pc), 64'(m_cur.b.pc));
        end
        if (live_ok && m_cur.b.mtc0) begin
            chk("cp0_addr", 64'(cp0_addr), 64'(m_cur.b.cp0_addr));
            chk("cp0_wdata", 64'(cp0_wdata), 64'(m_cur.b.result));
        end
        if (live_ok && m_cur.b.tlbp)
            chk("tlbp_idx", 64'({tlbp_found, tlbp_index}), 64'({m_cur.b.s1_found, m_cur.b.s1_index}));
    endtask

    // One clock: offer `in` (if v), advance the model at the edge, drive CP0 inputs, check at negedge.
    task automatic cycle(input logic v, input ins_t in, input logic rst);
        logic fl;
        reset = rst;
        ms_to_ws_valid = v;
        ms_to_ws_bus = in.b;
        @(posedge clk);
        if (rst) begin
            m_v = 1'b0;
            m_aex = 1'b0;
            m_cur = nop();
        end else begin
            fl = m_flush();
            m_aex = fl ? 1'b1 : (v ? 1'b0 : m_aex);
            m_v = v && !fl;
            if (v) m_cur = in;
        end
        #1;
        cp0_rdata = m_cur.rdata;
        cp0_epc = m_cur.epc;
        @(negedge clk);
        check_all();
    endtask

    function automatic vec_t blank(input string n);
        vec_t r;
        r.name = n;
        r.in = nop();
        r.e_we = 4'h0; r.e_wdata = 32'h0; r.e_blk = 1'b0; r.e_ex = 1'b0;
        r.e_eret = 1'b0; r.e_tlbwi = 1'b0; r.e_flush = 1'b0; r.e_fpc = 32'h0;
        return r;
    endfunction

    vec_t tbl[$];
    vec_t r;
    ins_t x, lw_a, lw_b, sys, mf;

    initial begin
        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; cp0_rdata = 0; cp0_epc = 0;
        cycle(1'b0, nop(), 1'b1);
        cycle(1'b0, nop(), 1'b1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        chk("rst_ws_pc", 64'(ws_pc), 64'd0);
        chk("rst_fwd", 64'(ws_fwd_blk_bus), 64'd0);
        chk("rst_after_ex", 64'(after_ex), 64'd0);

        r = blank("lw"); r.in.b.gr_strb = 4'hf; r.in.b.dest = 5; r.in.b.result = 32'h12345678;
        r.in.b.pc = 32'hbfc00000; r.e_we = 4'hf; r.e_wdata = 32'h12345678; tbl.push_back(r);
        r = blank("lwl"); r.in.b.gr_strb = 4'b1100; r.in.b.dest = 7; r.in.b.result = 32'haabb0000;
        r.e_we = 4'b1100; r.e_wdata = 32'haabb0000; tbl.push_back(r);
        r = blank("syscall"); r.in.b.ex = 1; r.in.b.syscall = 1; r.in.b.excode = 8; r.in.b.bd = 1;
        r.in.b.pc = 32'hbfc01000; r.in.b.gr_strb = 4'hf; r.e_ex = 1; r.e_flush = 1;
        r.e_fpc = 32'hbfc00380; tbl.push_back(r);
        r = blank("refill"); r.in.b.ex = 1; r.in.b.tlb_refill = 1; r.in.b.excode = 2;
        r.in.b.badvaddr = 32'h00400000; r.e_ex = 1; r.e_flush = 1; r.e_fpc = 32'hbfc00200; tbl.push_back(r);
        r = blank("eret"); r.in.b.eret = 1; r.in.epc = 32'hbfc02004; r.e_eret = 1; r.e_flush = 1;
        r.e_fpc = 32'hbfc02004; tbl.push_back(r);
        r = blank("tlbwi"); r.in.b.tlbwi = 1; r.in.b.after_tlb = 1; r.in.b.pc = 32'hbfc00ffc;
        r.e_tlbwi = 1; r.e_flush = 1; r.e_fpc = 32'hbfc01000; tbl.push_back(r);
        r = blank("mfc0"); r.in.b.mfc0 = 1; r.in.b.gr_strb = 4'hf; r.in.b.dest = 3;
        r.in.b.result = 32'h11111111; r.in.rdata = 32'hdeadbeef; r.e_we = 4'hf;
        r.e_wdata = 32'hdeadbeef; r.e_blk = 1; tbl.push_back(r);
        r = blank("ex_over"); r.in.b.ex = 1; r.in.b.eret = 1; r.in.b.after_tlb = 1; r.in.b.mtc0 = 1;
        r.in.b.tlbwi = 1; r.in.b.gr_strb = 4'hf; r.in.epc = 32'h12340000; r.e_ex = 1; r.e_flush = 1;
        r.e_fpc = 32'hbfc00380; tbl.push_back(r);
        r = blank("pc_wrap"); r.in.b.after_tlb = 1; r.in.b.tlbr = 1; r.in.b.pc = 32'hfffffffc;
        r.e_flush = 1; r.e_fpc = 32'h0; tbl.push_back(r);
        r = blank("dest0"); r.in.b.gr_strb = 4'hf; r.in.b.result = 32'h5; r.e_we = 4'hf;
        r.e_wdata = 32'h5; tbl.push_back(r);

        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].in, 1'b0);
            chk({tbl[i].name, ".we"}, 64'(rf_we), 64'(tbl[i].e_we));
            if (tbl[i].e_we != 0) chk({tbl[i].name, ".wdata"}, 64'(rf_wdata), 64'(tbl[i].e_wdata));
            chk({tbl[i].name, ".fwdv"}, 64'(ws_fwd_blk_bus[41:38]), 64'(tbl[i].e_we));
            chk({tbl[i].name, ".blk"}, 64'(ws_fwd_blk_bus[0]), 64'(tbl[i].e_blk));
            chk({tbl[i].name, ".ex"}, 64'(ws_ex), 64'(tbl[i].e_ex));
            chk({tbl[i].name, ".eret"}, 64'(ws_eret), 64'(tbl[i].e_eret));
            chk({tbl[i].name, ".tlbwi"}, 64'(tlbwi_we), 64'(tbl[i].e_tlbwi));
            chk({tbl[i].name, ".flush"}, 64'(do_flush), 64'(tbl[i].e_flush));
            if (tbl[i].e_flush) chk({tbl[i].name, ".fpc"}, 64'(flush_pc), 64'(tbl[i].e_fpc));
            cycle(1'b0, nop(), 1'b0);
            if (tbl[i].e_flush) chk({tbl[i].name, ".aex"}, 64'(after_ex), 64'd1);
        end

        // mfc0, syscall, then an instruction offered during the flush cycle that must be dropped.
        mf = nop(); mf.b.mfc0 = 1; mf.b.gr_strb = 4'hf; mf.b.dest = 9; mf.rdata = 32'hdeadbeef;
        sys = tbl[2].in;
        lw_a = nop(); lw_a.b.gr_strb = 4'hf; lw_a.b.dest = 4; lw_a.b.result = 32'haaaa5555;
        lw_b = lw_a; lw_b.b.dest = 6; lw_b.b.result = 32'h0badf00d;
        cycle(1'b1, mf, 1'b0);
        chk("seq.mfc0_blk", 64'(ws_fwd_blk_bus[0]), 64'd1);
        chk("seq.mfc0_data", 64'(rf_wdata), 64'hdeadbeef);
        cycle(1'b1, sys, 1'b0);
        chk("seq.sys_flush", 64'(do_flush), 64'd1);
        cycle(1'b1, lw_a, 1'b0);
        chk("seq.squash_we", 64'(rf_we), 64'd0);
        chk("seq.aex_set", 64'(after_ex), 64'd1);
        cycle(1'b0, nop(), 1'b0);
        chk("seq.aex_hold", 64'(after_ex), 64'd1);
        cycle(1'b1, lw_b, 1'b0);
        chk("seq.refill_we", 64'(rf_we), 64'hf);
        chk("seq.refill_data", 64'(rf_wdata), 64'h0badf00d);
        chk("seq.aex_clear", 64'(after_ex), 64'd0);

        // Reset while an eret is flushing: reset wins, nothing commits afterwards.
        cycle(1'b1, tbl[4].in, 1'b0);
        cycle(1'b1, lw_a, 1'b1);
        chk("rst.we", 64'(rf_we), 64'd0);
        chk("rst.flush", 64'(do_flush), 64'd0);
        chk("rst.aex", 64'(after_ex), 64'd0);
        chk("rst.eret", 64'(ws_eret), 64'd0);

        for (int k = 0; k < 600; k++) begin
            x = nop();
            x.b.tlb_refill = 1'($urandom);
            x.b.s1_index = 4'($urandom);
            x.b.s1_found = 1'($urandom);
            x.b.after_tlb = ($urandom_range(7) == 0);
            x.b.tlbp = ($urandom_range(5) == 0);
            x.b.tlbr = ($urandom_range(5) == 0);
            x.b.tlbwi = ($urandom_range(5) == 0);
            x.b.excode = 5'($urandom);
            x.b.badvaddr = $urandom;
            x.b.cp0_addr = 8'($urandom);
            x.b.ex = ($urandom_range(7) == 0);
            x.b.bd = 1'($urandom);
            x.b.eret = ($urandom_range(7) == 0);
            x.b.mfc0 = ($urandom_range(3) == 0);
            x.b.mtc0 = ($urandom_range(3) == 0);
            x.b.gr_strb = 4'($urandom);
            x.b.dest = 5'($urandom);
            x.b.result = $urandom;
            x.b.pc = $urandom;
            x.rdata = $urandom;
            x.epc = $urandom;
            cycle($urandom_range(3) != 0, x, $urandom_range(59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
